// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common-data-bus arbiter: FU result packets, the CDB
// broadcast packet and the default number of functional units.
package cdb_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int ROB_TAG_W      = 5;
  localparam int FU_IDX_W       = 3;
  localparam int NUM_FU_DEFAULT = 4;

  typedef struct packed {
    logic [XLEN-1:0]      v;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic                 take_branch;
    logic                 done;
  } FU_OUT_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [XLEN-1:0]      v;
    logic                 take_branch;
    logic [FU_IDX_W-1:0]  fu_idx;
  } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr_priority_sel.sv
// Purely combinational rotating priority search: returns a one-hot grant for
// the first set request found starting at index 'start' and wrapping.
module rr_priority_sel #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     grant
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   grant_rot;
  logic [2*N-1:0] grant_dbl;

  // Rotate so 'start' sits at bit 0, take the lowest set bit, rotate back.
  assign req_dbl   = {req, req} >> start;
  assign req_rot   = req_dbl[N-1:0];
  assign grant_rot = req_rot & (~req_rot + N'(1));
  assign grant_dbl = {grant_rot, grant_rot} << start;
  assign grant     = grant_dbl[2*N-1:N];

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one completed FU per cycle and registers its
// result onto the CDB. Define CDB_ROUND_ROBIN_EN for rotating priority.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  FU_OUT_PACKET       fu_out_packet [NUM_FU],
  input  logic               squash,
  output logic [NUM_FU-1:0]  ack,
  output CDB_PACKET          cdb_packet
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0] req;
  logic [NUM_FU-1:0] grant;
  logic [PTR_W-1:0]  ptr;
  CDB_PACKET         cand_chain [NUM_FU+1];
  CDB_PACKET         cdb_d;
  CDB_PACKET         cdb_q;

  // Each granted FU contributes its packet; ack is one-hot so an OR-chain muxes.
  assign cand_chain[0] = '0;
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    CDB_PACKET cand;
    assign req[gi]           = fu_out_packet[gi].done;
    assign cand.valid        = 1'b1;
    assign cand.rob_tag      = fu_out_packet[gi].rob_tag;
    assign cand.v            = fu_out_packet[gi].v;
    assign cand.take_branch  = fu_out_packet[gi].take_branch;
    assign cand.fu_idx       = FU_IDX_W'(gi);
    assign cand_chain[gi+1]  = cand_chain[gi] | (ack[gi] ? cand : '0);
  end

  rr_priority_sel #(
    .N     (NUM_FU),
    .PTR_W (PTR_W)
  ) u_sel (
    .req   (req),
    .start (ptr),
    .grant (grant)
  );

  assign ack = (reset || squash) ? '0 : grant;

`ifdef CDB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (|ack) begin
      if (int'(cdb_d.fu_idx) == NUM_FU - 1) ptr_d = '0;
      else                                   ptr_d = PTR_W'(cdb_d.fu_idx) + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    cdb_d = cand_chain[NUM_FU];
  end

  always_ff @(posedge clock) begin
    if (reset) cdb_q <= '0;
    else       cdb_q <= cdb_d;
  end

  assign cdb_packet = cdb_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations follow whichever priority mode
// CDB_ROUND_ROBIN_EN selects.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic         clock  = 1'b0;
  logic         reset  = 1'b1;
  logic         squash = 1'b0;
  FU_OUT_PACKET fu [N];
  logic [N-1:0] ack;
  CDB_PACKET    cdb_packet;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .fu_out_packet (fu),
    .squash        (squash),
    .ack           (ack),
    .cdb_packet    (cdb_packet)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post(input int i, input int tag, input logic [31:0] v, input logic tb);
    fu[i].rob_tag     = ROB_TAG_W'(tag);
    fu[i].v           = v;
    fu[i].take_branch = tb;
    fu[i].done        = 1'b1;
  endtask

  task automatic post_def(input int i);
    post(i, 10 + i, 32'hA000_0000 + 32'(i), i[0]);
  endtask

  function automatic CDB_PACKET expect_pkt(input int k);
    CDB_PACKET e;
    e = '0;
    if (k >= 0) begin
      e.valid       = 1'b1;
      e.rob_tag     = fu[k].rob_tag;
      e.v           = fu[k].v;
      e.take_branch = fu[k].take_branch;
      e.fu_idx      = FU_IDX_W'(k);
    end
    return e;
  endfunction

  // One bus cycle: check ack before the edge, the CDB after it, then the FU
  // drops done for whatever it was actually acked.
  task automatic cycle(input string tag, input logic [N-1:0] exp_ack, input int exp_k);
    CDB_PACKET    e;
    logic [N-1:0] seen;
    #1;
    check({tag, " ack"}, 64'(ack), 64'(exp_ack));
    seen = ack;
    e    = expect_pkt(exp_k);
    @(posedge clock);
    #1;
    check({tag, " cdb"}, 64'(cdb_packet), 64'(e));
    for (int i = 0; i < N; i++) if (seen[i]) fu[i].done = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) fu[i] = '0;
    for (int i = 0; i < N; i++) post_def(i);

    reset = 1'b1;
    cycle("rst0", 4'b0000, -1);
    cycle("rst1", 4'b0000, -1);
    reset = 1'b0;

    cycle("all0", 4'b0001, 0);
    cycle("all1", 4'b0010, 1);
    cycle("all2", 4'b0100, 2);
    cycle("all3", 4'b1000, 3);
    cycle("idle0", 4'b0000, -1);

    post_def(1);
    post_def(3);
    squash = 1'b1;
    cycle("squash", 4'b0000, -1);
    squash = 1'b0;
    cycle("sq_fu1", 4'b0010, 1);
    cycle("sq_fu3", 4'b1000, 3);

    post(2, 5, 32'h1234, 1'b0);
    cycle("single", 4'b0100, 2);
    check("single tag", 64'(cdb_packet.rob_tag), 64'd5);
    cycle("single_idle", 4'b0000, -1);

    post_def(0);
    post_def(3);
`ifdef CDB_ROUND_ROBIN_EN
    cycle("wrap_a", 4'b1000, 3);
    cycle("wrap_b", 4'b0001, 0);
`else
    cycle("wrap_a", 4'b0001, 0);
    cycle("wrap_b", 4'b1000, 3);
`endif

    post_def(0);
    post_def(1);
`ifdef CDB_ROUND_ROBIN_EN
    cycle("ptr_a", 4'b0010, 1);
    cycle("ptr_b", 4'b0001, 0);
`else
    cycle("ptr_a", 4'b0001, 0);
    cycle("ptr_b", 4'b0010, 1);
`endif

    post_def(3);
    for (int c = 0; c < 4; c++) begin
      post_def(0);
`ifdef CDB_ROUND_ROBIN_EN
      if (c == 0) cycle("starve", 4'b1000, 3);
      else        cycle("starve", 4'b0001, 0);
`else
      cycle("starve", 4'b0001, 0);
`endif
    end
`ifdef CDB_ROUND_ROBIN_EN
    cycle("drain", 4'b0000, -1);
`else
    cycle("drain", 4'b1000, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
